axil_irq_ctrl: RTL and testbench
================================

Name: axil_irq_ctrl

Overview:
- Native, parametrised AXI-Lite interrupt controller with 1..32 sources, all in the `aclk` domain.
- Each source is individually configurable:
  - edge or level sensitive;
  - active-high or active-low;
  - enable bit plus write-1-to-clear acknowledge.
- Produces a single registered `irq_o` to the CPU and a priority vector register (lowest index wins).
- Sits on the peripheral AXI-Lite crossbar next to UART/timer/GPIO slaves.

Parameters:
- `NUM_IRQ`, 8: number of interrupt inputs, legal 1..32.
- `KIND_RST`, 32'hFFFF_FFFF: reset value of KIND (bit=1 edge, 0 level).
- `POL_RST`, 32'h0000_0000: reset value of POL (bit=1 active-low).

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  synchronous active-low reset.
- `slv`  AXI_LITE.Slave  32-bit data  register interface; `addr[5:0]` decoded, `addr[1:0]` ignored.
- `irq_i`  in  `NUM_IRQ`  interrupt sources, synchronous to `aclk`.
- `irq_o`  out  1  combined interrupt request, registered.

Behaviour:
- Register map (bits >= `NUM_IRQ` read 0 and ignore writes):
  - 0x00 ISR: RO pending vector.
  - 0x04 IPR: RO, ISR & IER.
  - 0x08 IER: RW, byte strobes honoured.
  - 0x0C IAR: WO, W1C pending (edge sources only).
  - 0x10 SIE: W1S IER.
  - 0x14 CIE: W1C IER.
  - 0x18 IVR: RO, index of lowest set IPR bit, 32'hFFFF_FFFF if none.
  - 0x1C MER: bit0 master enable, RW.
  - 0x20 KIND: RW.
  - 0x24 POL: RW.
  - Write-only registers read 0.
  - Other offsets: read data 0 with `r_resp`=SLVERR (2'b10); writes dropped with `b_resp`=SLVERR. Mapped accesses return OKAY.
- Source conditioning:
  - `act[i] = irq_i[i] ^ POL[i]`.
  - `prev` register holds `act` from the previous cycle; `prev` resets to all-ones, so an input already asserted at reset gives no edge.
- Pending update, edge sources (KIND=1):
  - `ISR[i] <= ISR[i] & ~ack[i] | (act[i] & ~prev[i])`.
  - Set wins over a same-cycle IAR ack.
- Pending update, level sources (KIND=0):
  - `ISR[i] <= act[i]` every cycle.
  - IAR has no effect.
- A KIND/POL write takes effect on the following cycle. Existing edge-pending bits are retained; level bits are overwritten.
- `irq_o <= MER[0] & |(ISR & IER)`.
- Latency: `irq_i` rises at edge t (seen in cycle t) → ISR set at edge t+1 → `irq_o` high at edge t+2.
- After an IAR write completes (W handshake at edge t), ISR clears at edge t; `irq_o` drops at edge t+1 unless other pending bits are enabled.
- Write FSM, `WR_IDLE` → `WR_RESP`:
  - In IDLE, `aw_ready` = `w_ready` = `aw_valid & w_valid`; both channels handshake in the same cycle and the register update takes effect at that edge.
  - In RESP, `b_valid`=1 until `b_ready`, then return to IDLE.
  - No new AW/W is accepted while in RESP.
- Read FSM, `RD_IDLE` → `RD_DATA`:
  - `ar_ready`=1 in IDLE; `r_data`/`r_resp` are captured at the AR handshake.
  - In DATA, `r_valid`=1 and data is held stable until `r_ready`.
  - `ar_ready`=0 in DATA.
- A read and a write may proceed concurrently. A read captured in the same cycle as a write returns the pre-write value.
- Reset values:
  - ISR, IER, MER: 0.
  - KIND = `KIND_RST`, POL = `POL_RST`.
  - `irq_o`, `aw_ready`, `w_ready`, `b_valid`, `r_valid`: 0.
  - `ar_ready`: 1 from the first cycle after reset deasserts.
  - Both FSMs in IDLE.
  - Reset mid-transaction abandons it: `b_valid`/`r_valid` drop the cycle reset is sampled.

Decomposition:
- Package `axil_irq_ctrl_pkg`:
  - register offset localparams (`REG_ISR`..`REG_POL`);
  - `RESP_OKAY`/`RESP_SLVERR`;
  - `wr_state_e`/`rd_state_e` enums;
  - `MAX_IRQ`=32.
- Sub-module `irq_src_cell`, one per source via generate:
  - inputs: `irq_i`, KIND, POL, ack;
  - holds `prev` and the ISR bit;
  - outputs: pending.
- Top level keeps the AXI FSMs, config registers, priority encoder and `irq_o` register.

Test Plan:
- Edge capture: `NUM_IRQ`=8, IER=0xFF, MER=1; pulse `irq_i[3]` for 1 cycle → ISR=0x08, `irq_o` rises 2 cycles after the pulse, IVR=3; IAR write 0x08 → ISR=0, `irq_o` low next cycle.
- Level mode and polarity: KIND=0xFE, POL=0x01. Hold `irq_i[0]`=0 → ISR[0]=1. IAR 0x01 → ISR[0] stays 1. Set `irq_i[0]`=1 → ISR[0]=0 next cycle, `irq_o`=0.
- Priority and masking: pulse `irq_i[5]`, `irq_i[2]`.
  - IER=0x24 → IVR=2.
  - CIE 0x04 → IPR=0x20, IVR=5.
  - MER=0 → `irq_o`=0 while ISR=0x24.
- Set-vs-ack collision: IAR write 0x02 in the same cycle as a new rising edge on `irq_i[1]` → ISR[1] remains 1.
- AXI corner cases:
  - Read 0x30 → `r_data`=0, `r_resp`=2'b10.
  - Write IER with `w_strb`=4'b0010, data 0xFFFF → IER=0xFF00 masked to `NUM_IRQ` bits.
  - Withhold `b_ready` 5 cycles → `b_valid` held, second AW not accepted.
- Reset behaviour: drive `irq_i`=0xFF through reset → no edge pending after reset. Assert `aresetn`=0 while `r_valid` is pending → `r_valid`=0, IER=0, KIND=`KIND_RST`.

Source files
------------

// File: rtl/axil_irq_ctrl_pkg.sv
// Shared constants and types for the AXI-Lite interrupt controller.
// Register offsets are byte addresses within the 64-byte window.
package axil_irq_ctrl_pkg;

  localparam int MAX_IRQ = 32;

  localparam logic [5:0] REG_ISR  = 6'h00;
  localparam logic [5:0] REG_IPR  = 6'h04;
  localparam logic [5:0] REG_IER  = 6'h08;
  localparam logic [5:0] REG_IAR  = 6'h0C;
  localparam logic [5:0] REG_SIE  = 6'h10;
  localparam logic [5:0] REG_CIE  = 6'h14;
  localparam logic [5:0] REG_IVR  = 6'h18;
  localparam logic [5:0] REG_MER  = 6'h1C;
  localparam logic [5:0] REG_KIND = 6'h20;
  localparam logic [5:0] REG_POL  = 6'h24;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_e;

  // Offsets are word aligned, so everything up to POL is a real register.
  function automatic logic is_mapped(input logic [5:0] off);
    return off <= REG_POL;
  endfunction

endpackage

// File: rtl/axil_irq_ctrl_if.sv
// AXI-Lite bus bundle (32-bit address and data) with master/slave views.
interface axil_irq_ctrl_if;
  logic [31:0] aw_addr;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_valid;
  logic        w_ready;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready;
  logic [31:0] ar_addr;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_valid;
  logic        r_ready;

  modport master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axil_irq_ctrl_src_cell.sv
// One interrupt source: polarity fix-up, edge detect and the pending bit.
// prev resets high so a source already active at reset is not seen as an edge.
module irq_src_cell (
  input  logic aclk,
  input  logic aresetn,
  input  logic irq_i,
  input  logic kind,
  input  logic pol,
  input  logic ack,
  output logic pending
);
  logic act;
  logic prev;

  assign act = irq_i ^ pol;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      prev    <= 1'b1;
      pending <= 1'b0;
    end else begin
      prev    <= act;
      // A fresh edge beats a same-cycle acknowledge.
      pending <= kind ? ((pending & ~ack) | (act & ~prev)) : act;
    end
  end
endmodule

// File: rtl/axil_irq_ctrl.sv
// AXI-Lite interrupt controller: per-source cells, config registers,
// lowest-index priority vector and a registered combined irq_o.
module axil_irq_ctrl #(
  parameter int unsigned NUM_IRQ  = 8,
  parameter logic [31:0] KIND_RST = 32'hFFFF_FFFF,
  parameter logic [31:0] POL_RST  = 32'h0000_0000
) (
  input  logic               aclk,
  input  logic               aresetn,
  axil_irq_ctrl_if.slave     slv,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               irq_o
);
  import axil_irq_ctrl_pkg::*;

  wr_state_e wr_state, wr_next;
  rd_state_e rd_state, rd_next;

  logic [NUM_IRQ-1:0] isr, ipr, ier, kind, pol, ack, wmask, wbits;
  logic               mer;
  logic [31:0]        strb_mask, wfull, ivr, rd_mux;
  logic [5:0]         wr_off, rd_off;
  logic               wr_fire, rd_fire, rd_err;

  assign wr_off  = {slv.aw_addr[5:2], 2'b00};
  assign rd_off  = {slv.ar_addr[5:2], 2'b00};
  assign wr_fire = aresetn && (wr_state == WR_IDLE) && slv.aw_valid && slv.w_valid;
  assign rd_fire = aresetn && (rd_state == RD_IDLE) && slv.ar_valid;

  always_comb begin
    for (int b = 0; b < 4; b++) strb_mask[b*8 +: 8] = {8{slv.w_strb[b]}};
  end
  assign wfull = slv.w_data & strb_mask;
  assign wmask = strb_mask[NUM_IRQ-1:0];
  assign wbits = wfull[NUM_IRQ-1:0];
  assign ack   = (wr_fire && wr_off == REG_IAR) ? wbits : '0;

  logic unused_bits;
  assign unused_bits = ^{slv.aw_addr[31:6], slv.aw_addr[1:0],
                         slv.ar_addr[31:6], slv.ar_addr[1:0], wfull};

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
    irq_src_cell u_cell (
      .aclk    (aclk),
      .aresetn (aresetn),
      .irq_i   (irq_i[i]),
      .kind    (kind[i]),
      .pol     (pol[i]),
      .ack     (ack[i]),
      .pending (isr[i])
    );
  end

  assign ipr = isr & ier;

  always_comb begin
    ivr = '1;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (ipr[i]) ivr = 32'(i);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ier  <= '0;
      mer  <= 1'b0;
      kind <= KIND_RST[NUM_IRQ-1:0];
      pol  <= POL_RST[NUM_IRQ-1:0];
    end else if (wr_fire) begin
      case (wr_off)
        REG_IER:  ier  <= (ier & ~wmask) | wbits;
        REG_SIE:  ier  <= ier | wbits;
        REG_CIE:  ier  <= ier & ~wbits;
        REG_MER:  if (slv.w_strb[0]) mer <= slv.w_data[0];
        REG_KIND: kind <= (kind & ~wmask) | wbits;
        REG_POL:  pol  <= (pol & ~wmask) | wbits;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) irq_o <= 1'b0;
    else          irq_o <= mer & (|ipr);
  end

  // Read data reflects registers before any write landing on the same edge.
  always_comb begin
    rd_mux = '0;
    rd_err = 1'b0;
    case (rd_off)
      REG_ISR:                   rd_mux = 32'(isr);
      REG_IPR:                   rd_mux = 32'(ipr);
      REG_IER:                   rd_mux = 32'(ier);
      REG_IVR:                   rd_mux = ivr;
      REG_MER:                   rd_mux = {31'b0, mer};
      REG_KIND:                  rd_mux = 32'(kind);
      REG_POL:                   rd_mux = 32'(pol);
      REG_IAR, REG_SIE, REG_CIE: rd_mux = '0;
      default:                   rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next      = wr_state;
    slv.aw_ready = 1'b0;
    slv.w_ready  = 1'b0;
    slv.b_valid  = 1'b0;
    case (wr_state)
      WR_IDLE: begin
        slv.aw_ready = wr_fire;
        slv.w_ready  = wr_fire;
        if (wr_fire) wr_next = WR_RESP;
      end
      WR_RESP: begin
        slv.b_valid = 1'b1;
        if (slv.b_ready) wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next      = rd_state;
    slv.ar_ready = 1'b0;
    slv.r_valid  = 1'b0;
    case (rd_state)
      RD_IDLE: begin
        slv.ar_ready = aresetn;
        if (rd_fire) rd_next = RD_DATA;
      end
      RD_DATA: begin
        slv.r_valid = 1'b1;
        if (slv.r_ready) rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      slv.r_data <= '0;
      slv.r_resp <= RESP_OKAY;
      slv.b_resp <= RESP_OKAY;
    end else begin
      if (rd_fire) begin
        slv.r_data <= rd_mux;
        slv.r_resp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
      if (wr_fire) slv.b_resp <= is_mapped(wr_off) ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_axil_irq_ctrl.sv
// Bench for axil_irq_ctrl: directed scenarios plus random traffic, checked
// every cycle against a register-level reference model.
module tb_axil_irq_ctrl;
  localparam int          N        = 8;
  localparam logic [31:0] KIND_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] POL_RST  = 32'h0000_0000;
  localparam logic [31:0] NMASK    = (N == 32) ? 32'hFFFF_FFFF : ((32'h1 << N) - 32'h1);

  logic         aclk = 1'b0;
  logic         rstn;
  logic [N-1:0] irq;
  logic         irq_o;

  axil_irq_ctrl_if bus ();

  axil_irq_ctrl #(.NUM_IRQ(N), .KIND_RST(KIND_RST), .POL_RST(POL_RST)) dut (
    .aclk    (aclk),
    .aresetn (rstn),
    .slv     (bus),
    .irq_i   (irq),
    .irq_o   (irq_o)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  logic [31:0] m_isr = 0, m_prev = 0, m_ier = 0, m_kind = 0, m_pol = 0, m_rdata = 0;
  logic        m_mer = 0, m_irq = 0, m_bpend = 0, m_rpend = 0;
  logic [1:0]  m_rresp = 0, m_bresp = 0;

  logic [31:0] rd;
  logic [1:0]  rsp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [5:0] off, output logic [1:0] resp);
    logic [31:0] ipr, v;
    logic        found;
    resp = 2'b00;
    ipr  = m_isr & m_ier;
    v    = 32'hFFFF_FFFF;
    found = 1'b0;
    for (int i = 0; i < N; i++)
      if (!found && ipr[i]) begin v = i; found = 1'b1; end
    case (off)
      6'h00: return m_isr;
      6'h04: return ipr;
      6'h08: return m_ier;
      6'h0C, 6'h10, 6'h14: return 32'h0;
      6'h18: return v;
      6'h1C: return {31'b0, m_mer};
      6'h20: return m_kind;
      6'h24: return m_pol;
      default: begin resp = 2'b10; return 32'h0; end
    endcase
  endfunction

  // Advance model and DUT by one clock, then compare observable outputs.
  task automatic tick();
    logic        fw, fr;
    logic [5:0]  wo, ro;
    logic [31:0] wm, wb, act, ack, nisr;
    logic [1:0]  rr;
    fw = rstn && bus.aw_valid && bus.w_valid && !m_bpend;
    fr = rstn && bus.ar_valid && !m_rpend;
    wo = {bus.aw_addr[5:2], 2'b00};
    ro = {bus.ar_addr[5:2], 2'b00};
    for (int b = 0; b < 4; b++) wm[b*8 +: 8] = {8{bus.w_strb[b]}};
    wb   = bus.w_data & wm & NMASK;
    ack  = (fw && wo == 6'h0C) ? wb : 32'h0;
    act  = (32'(irq) ^ m_pol) & NMASK;
    nisr = 32'h0;
    for (int i = 0; i < N; i++)
      nisr[i] = m_kind[i] ? ((m_isr[i] & ~ack[i]) | (act[i] & ~m_prev[i])) : act[i];
    if (fr) begin m_rdata = mread(ro, rr); m_rresp = rr; end
    m_irq = m_mer & (|(m_isr & m_ier));
    if (fw) begin
      m_bresp = (wo <= 6'h24) ? 2'b00 : 2'b10;
      case (wo)
        6'h08: m_ier  = (m_ier & ~wm) | wb;
        6'h10: m_ier  = m_ier | wb;
        6'h14: m_ier  = m_ier & ~wb;
        6'h1C: if (bus.w_strb[0]) m_mer = bus.w_data[0];
        6'h20: m_kind = (m_kind & ~wm) | wb;
        6'h24: m_pol  = (m_pol & ~wm) | wb;
        default: ;
      endcase
    end
    m_isr  = nisr;
    m_prev = act;
    if (fw) m_bpend = 1'b1; else if (m_bpend && bus.b_ready) m_bpend = 1'b0;
    if (fr) m_rpend = 1'b1; else if (m_rpend && bus.r_ready) m_rpend = 1'b0;
    if (!rstn) begin
      m_isr = 0; m_prev = NMASK; m_ier = 0; m_mer = 0; m_irq = 0;
      m_kind = KIND_RST & NMASK; m_pol = POL_RST & NMASK;
      m_bpend = 0; m_rpend = 0;
    end
    @(posedge aclk);
    #1;
    chk("irq_o", irq_o, m_irq);
    chk("b_valid", bus.b_valid, m_bpend);
    chk("r_valid", bus.r_valid, m_rpend);
    chk("ar_ready", bus.ar_ready, rstn && !m_rpend);
    if (m_bpend) chk("b_resp", bus.b_resp, m_bresp);
    if (m_rpend) begin
      chk("r_data", bus.r_data, m_rdata);
      chk("r_resp", bus.r_resp, m_rresp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int dly, output logic [1:0] resp);
    bus.aw_addr = addr; bus.w_data = data; bus.w_strb = strb;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    repeat (dly) tick();
    resp = bus.b_resp;
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int dly,
                          output logic [31:0] data, output logic [1:0] resp);
    bus.ar_addr = addr; bus.ar_valid = 1'b1;
    tick();
    bus.ar_valid = 1'b0;
    repeat (dly) tick();
    data = bus.r_data; resp = bus.r_resp;
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.aw_addr = 0; bus.aw_valid = 0; bus.w_data = 0; bus.w_strb = 0; bus.w_valid = 0;
    bus.b_ready = 0; bus.ar_addr = 0; bus.ar_valid = 0; bus.r_ready = 0;

    // reset with all sources held active: no edge may be captured
    rstn = 1'b0; irq = 8'hFF;
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    chk("rst_ar_ready", bus.ar_ready, 1);
    tick();
    axi_read(32'h00, 0, rd, rsp); chk("rst_isr", rd, 0);
    axi_read(32'h20, 0, rd, rsp); chk("rst_kind", rd, 32'hFF);
    irq = 8'h00; tick();

    // edge capture and latency
    axi_write(32'h08, 32'hFF, 4'hF, 0, rsp);
    axi_write(32'h1C, 32'h1, 4'hF, 0, rsp);
    irq = 8'h08; tick();
    irq = 8'h00;
    chk("edge_irq_t1", irq_o, 0);
    tick();
    chk("edge_irq_t2", irq_o, 1);
    axi_read(32'h00, 0, rd, rsp); chk("edge_isr", rd, 32'h08);
    axi_read(32'h18, 1, rd, rsp); chk("edge_ivr", rd, 3);
    axi_write(32'h0C, 32'h08, 4'hF, 0, rsp);
    axi_read(32'h00, 0, rd, rsp); chk("ack_isr", rd, 0);
    chk("ack_irq_o", irq_o, 0);

    // level sensitivity with active-low source 0
    axi_write(32'h24, 32'h01, 4'hF, 0, rsp);
    axi_write(32'h20, 32'hFE, 4'hF, 0, rsp);
    axi_read(32'h00, 0, rd, rsp); chk("lvl_isr", rd, 32'h01);
    axi_write(32'h0C, 32'h01, 4'hF, 0, rsp);
    axi_read(32'h00, 0, rd, rsp); chk("lvl_ack_noeff", rd, 32'h01);
    irq = 8'h01; tick(); tick();
    chk("lvl_irq_o", irq_o, 0);
    axi_read(32'h00, 0, rd, rsp); chk("lvl_clear", rd, 0);
    irq = 8'h00;
    axi_write(32'h24, 32'h00, 4'hF, 0, rsp);
    axi_write(32'h20, 32'hFF, 4'hF, 0, rsp);
    axi_write(32'h0C, 32'hFF, 4'hF, 0, rsp);

    // priority and masking
    irq = 8'h24; tick();
    irq = 8'h00; tick();
    axi_write(32'h08, 32'h24, 4'hF, 0, rsp);
    axi_read(32'h18, 0, rd, rsp); chk("prio_ivr2", rd, 2);
    axi_write(32'h14, 32'h04, 4'hF, 0, rsp);
    axi_read(32'h04, 0, rd, rsp); chk("prio_ipr", rd, 32'h20);
    axi_read(32'h18, 0, rd, rsp); chk("prio_ivr5", rd, 5);
    axi_write(32'h1C, 32'h0, 4'hF, 0, rsp);
    tick(); tick();
    chk("mer_off_irq", irq_o, 0);
    axi_read(32'h00, 0, rd, rsp); chk("mer_off_isr", rd, 32'h24);
    axi_write(32'h1C, 32'h1, 4'hF, 0, rsp);
    axi_write(32'h0C, 32'hFF, 4'hF, 0, rsp);
    axi_write(32'h08, 32'hFF, 4'hF, 0, rsp);

    // new edge in the same cycle as its acknowledge
    irq = 8'h02; tick();
    irq = 8'h00; tick(); tick();
    irq = 8'h02;
    axi_write(32'h0C, 32'h02, 4'hF, 0, rsp);
    axi_read(32'h00, 0, rd, rsp); chk("collide_isr1", rd[1], 1);
    irq = 8'h00;
    axi_write(32'h0C, 32'h02, 4'hF, 0, rsp);
    axi_read(32'h00, 0, rd, rsp); chk("collide_clr", rd, 0);

    // bus corner cases
    axi_read(32'h30, 0, rd, rsp);
    chk("bad_rd_data", rd, 0); chk("bad_rd_resp", rsp, 2'b10);
    axi_write(32'h30, 32'hFFFF_FFFF, 4'hF, 0, rsp); chk("bad_wr_resp", rsp, 2'b10);
    axi_write(32'h08, 32'h0, 4'hF, 0, rsp);
    axi_write(32'h08, 32'hFFFF, 4'b0010, 0, rsp); chk("strb_resp", rsp, 2'b00);
    axi_read(32'h08, 0, rd, rsp); chk("strb_ier_hi", rd, 0);
    axi_write(32'h08, 32'h1234, 4'b0001, 0, rsp);
    axi_read(32'h08, 0, rd, rsp); chk("strb_ier_lo", rd, 32'h34);

    // withheld b_ready blocks a second write
    bus.aw_addr = 32'h10; bus.w_data = 32'h01; bus.w_strb = 4'hF;
    bus.aw_valid = 1'b1; bus.w_valid = 1'b1;
    tick();
    bus.w_data = 32'h80;
    for (int k = 0; k < 5; k++) begin
      chk("bhold_valid", bus.b_valid, 1);
      chk("bhold_awrdy", bus.aw_ready, 0);
      tick();
    end
    bus.b_ready = 1'b1;
    tick();
    chk("bhold_accept", bus.aw_ready, 1);
    tick();
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0;
    tick();
    bus.b_ready = 1'b0;
    axi_read(32'h08, 0, rd, rsp); chk("bhold_ier", rd, 32'hB5);

    // random traffic against the model
    for (int it = 0; it < 400; it++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 5) begin
        irq = N'($urandom);
        tick();
      end else if (op < 8) begin
        axi_write(32'(4 * $urandom_range(0, 15)), $urandom, 4'($urandom),
                  $urandom_range(0, 2), rsp);
      end else begin
        axi_read(32'(4 * $urandom_range(0, 15)), $urandom_range(0, 2), rd, rsp);
      end
    end
    irq = 8'h00;
    tick();

    // reset abandons an outstanding read and restores config
    axi_write(32'h08, 32'h5A, 4'hF, 0, rsp);
    axi_write(32'h20, 32'h0F, 4'hF, 0, rsp);
    bus.ar_addr = 32'h08; bus.ar_valid = 1'b1;
    tick();
    bus.ar_valid = 1'b0;
    tick();
    chk("mid_rvalid", bus.r_valid, 1);
    rstn = 1'b0;
    tick();
    chk("rst_rvalid", bus.r_valid, 0);
    rstn = 1'b1;
    tick();
    axi_read(32'h08, 0, rd, rsp); chk("rst_ier", rd, 0);
    axi_read(32'h20, 0, rd, rsp); chk("rst_kind2", rd, 32'hFF);
    axi_read(32'h1C, 0, rd, rsp); chk("rst_mer", rd, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
